// File: rtl/demux1_4_stream.sv
// demux1_4_stream: 1-to-4 valid/ready stream demultiplexer.
// The first beat of a packet picks the output port from s_sel. The port stays
// locked until the beat carrying s_last has been accepted. Each output port is
// a single registered slice, so there is no combinational path from m_ready to
// m_valid.
// Optional feature: define DEMUX4_CNT_EN to get per-port accepted-beat counters
// on m_cnt. When it is undefined, m_cnt is tied to zero.
module demux1_4_stream #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [1:0]      s_sel,
    input  logic [DW-1:0]   s_data,
    input  logic            s_last,
    output logic [3:0]      m_valid,
    input  logic [3:0]      m_ready,
    output logic [4*DW-1:0] m_data,
    output logic [3:0]      m_last,
    output logic            busy,
    output logic [4*CW-1:0] m_cnt
);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    lock_port_reg, lock_port_next;
    logic [1:0]    target;
    logic [3:0]    free;
    logic [3:0]    load;
    logic          accept;
    logic [3:0]    vld_reg;
    logic [3:0]    last_reg;
    logic [DW-1:0] data_reg [4];

    // While a packet is open, s_sel is ignored and the locked port is used.
    assign target  = (state_reg == LOCK) ? lock_port_reg : s_sel;
    assign free    = ~vld_reg | m_ready;
    assign s_ready = ~rst & free[target];
    assign accept  = s_valid & s_ready;
    assign busy    = (state_reg == LOCK);
    assign m_valid = vld_reg;
    assign m_last  = last_reg;

    // Packet-lock state and locked port register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            lock_port_reg <= 2'd0;
        end else begin
            state_reg     <= state_next;
            lock_port_reg <= lock_port_next;
        end
    end

    // Next state: open on a non-final first beat, close on any accepted last beat.
    always_comb begin
        state_next     = state_reg;
        lock_port_next = lock_port_reg;
        if (accept) begin
            if (s_last) begin
                state_next = IDLE;
            end else if (state_reg == IDLE) begin
                state_next     = LOCK;
                lock_port_next = s_sel;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign load[gi] = accept & (target == 2'(gi));
            assign m_data[gi*DW +: DW] = data_reg[gi];

            // Output slice: load wins over drain, and payload changes only on load.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_reg[gi]  <= 1'b0;
                    last_reg[gi] <= 1'b0;
                    data_reg[gi] <= '0;
                end else if (load[gi]) begin
                    vld_reg[gi]  <= 1'b1;
                    last_reg[gi] <= s_last;
                    data_reg[gi] <= s_data;
                end else if (m_ready[gi]) begin
                    vld_reg[gi]  <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef DEMUX4_CNT_EN
    logic [CW-1:0] cnt_reg [4];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_cnt
            assign m_cnt[gi*CW +: CW] = cnt_reg[gi];

            // Count beats handed to the consumer; the count wraps naturally at 2^CW.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (vld_reg[gi] & m_ready[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CW'(1);
                end
            end
        end
    endgenerate
`else
    assign m_cnt = '0;
`endif

endmodule

// File: tb/tb_demux1_4_stream.sv
// tb_demux1_4_stream: directed scenarios plus randomized traffic. A behavioural
// port model is compared against the DUT on every falling edge. The counter
// checks follow DEMUX4_CNT_EN.
module tb_demux1_4_stream;
    localparam int DW = 8;
    localparam int CW = 4;
`ifdef DEMUX4_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [1:0]      s_sel = 2'd0;
    logic [DW-1:0]   s_data = '0;
    logic            s_last = 1'b0;
    logic [3:0]      m_valid;
    logic [3:0]      m_ready = 4'h0;
    logic [4*DW-1:0] m_data;
    logic [3:0]      m_last;
    logic            busy;
    logic [4*CW-1:0] m_cnt;

    demux1_4_stream #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sel(s_sel),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy), .m_cnt(m_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each port holds at most one beat. A packet's port is remembered from its
    // first beat until its last beat.
    logic [3:0]    mv = '0;
    logic [3:0]    ml = '0;
    logic [DW-1:0] md [4] = '{default: '0};
    logic [CW-1:0] mc [4] = '{default: '0};
    bit            in_pkt = 1'b0;
    logic [1:0]    lport = 2'd0;
    logic [1:0]    mt;
    bit            macc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mv = '0; ml = '0; in_pkt = 1'b0; lport = 2'd0;
            for (int i = 0; i < 4; i++) begin md[i] = '0; mc[i] = '0; end
        end else begin
            mt   = in_pkt ? lport : s_sel;
            macc = s_valid && (!mv[mt] || m_ready[mt]);
            for (int i = 0; i < 4; i++) begin
                if (CNT_EN && mv[i] && m_ready[i]) mc[i] = mc[i] + 1'b1;
                if (macc && mt == 2'(i)) begin
                    mv[i] = 1'b1; md[i] = s_data; ml[i] = s_last;
                end else if (m_ready[i]) begin
                    mv[i] = 1'b0;
                end
            end
            if (macc) begin
                if (s_last) in_pkt = 1'b0;
                else if (!in_pkt) begin in_pkt = 1'b1; lport = s_sel; end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            logic [1:0]      t;
            logic [4*DW-1:0] ed;
            logic [4*CW-1:0] ec;
            t = in_pkt ? lport : s_sel;
            for (int i = 0; i < 4; i++) begin
                ed[i*DW +: DW] = md[i];
                ec[i*CW +: CW] = mc[i];
            end
            chk("s_ready", 64'(s_ready), 64'(!rst && (!mv[t] || m_ready[t])));
            chk("busy", 64'(busy), 64'(in_pkt));
            chk("m_valid", 64'(m_valid), 64'(mv));
            chk("m_last", 64'(m_last), 64'(ml));
            chk("m_data", 64'(m_data), 64'(ed));
            chk("m_cnt", 64'(m_cnt), 64'(ec));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [DW-1:0] d, input logic l);
        s_valid = v; s_sel = sel; s_data = d; s_last = l;
    endtask

    function automatic logic [DW-1:0] pdata(input int p);
        return m_data[p*DW +: DW];
    endfunction

    logic [1:0]    t2_sel [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
    logic [DW-1:0] t2_dat [4] = '{8'hA3, 8'hB1, 8'hC0, 8'hD2};
    logic [1:0]    t3_sel [4] = '{2'd2, 2'd0, 2'd1, 2'd3};

    initial begin
        step(); step();
        chk("reset m_valid", 64'(m_valid), 64'h0);
        chk("reset s_ready", 64'(s_ready), 64'h0);
        chk("reset m_cnt", 64'(m_cnt), 64'h0);
        rst = 1'b0;
        run_cmp = 1'b1;

        // Single-beat packets to every port.
        m_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, t2_sel[k], t2_dat[k], 1'b1);
            #1 chk("t2 s_ready", 64'(s_ready), 64'h1);
            step();
            chk("t2 m_valid", 64'(m_valid), 64'(4'b0001 << t2_sel[k]));
            chk("t2 m_data", 64'(pdata(int'(t2_sel[k]))), 64'(t2_dat[k]));
        end

        // A four-beat packet stays on port 2 while s_sel wanders.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, t3_sel[k], 8'(8'h20 + k), k == 3);
            step();
            chk("t3 m_valid", 64'(m_valid), 64'h4);
            chk("t3 m_data", 64'(pdata(2)), 64'(8'h20 + k));
            chk("t3 busy", 64'(busy), 64'(k < 3));
        end

        // Backpressure on port 1.
        m_ready = 4'b1101;
        drive(1'b1, 2'd1, 8'h41, 1'b1);
        step();
        drive(1'b1, 2'd1, 8'h42, 1'b1);
        #1 chk("t4 stall s_ready", 64'(s_ready), 64'h0);
        step(); step();
        chk("t4 held data", 64'(pdata(1)), 64'h41);
        m_ready = 4'hF;
        #1 chk("t4 release s_ready", 64'(s_ready), 64'h1);
        step();
        chk("t4 reload data", 64'(pdata(1)), 64'h42);
        chk("t4 reload valid", 64'(m_valid[1]), 64'h1);
        s_valid = 1'b0;
        step();
        chk("t4 drained", 64'(m_valid[1]), 64'h0);

        // Port 3 drains while port 0 drains and reloads in the same cycle.
        m_ready = 4'h0;
        drive(1'b1, 2'd0, 8'h10, 1'b1);
        step();
        drive(1'b1, 2'd3, 8'h30, 1'b1);
        step();
        s_valid = 1'b0;
        chk("t5 both full", 64'(m_valid), 64'h9);
        m_ready = 4'b1001;
        drive(1'b1, 2'd0, 8'h55, 1'b1);
        step();
        s_valid = 1'b0;
        chk("t5 m_valid", 64'(m_valid), 64'h1);
        chk("t5 port0 data", 64'(pdata(0)), 64'h55);
        chk("t5 port3 data held", 64'(pdata(3)), 64'h30);

        // Reset in the middle of an open, stalled packet.
        m_ready = 4'h0;
        drive(1'b1, 2'd0, 8'h01, 1'b1);
        step();
        drive(1'b1, 2'd1, 8'h02, 1'b0);
        step();
        chk("t1 busy before", 64'(busy), 64'h1);
        drive(1'b1, 2'd2, 8'h03, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("t1 m_valid", 64'(m_valid), 64'h0);
        chk("t1 busy", 64'(busy), 64'h0);
        chk("t1 s_ready", 64'(s_ready), 64'h0);
        chk("t1 m_cnt", 64'(m_cnt), 64'h0);
        chk("t1 m_data", 64'(m_data), 64'h0);
        step(); step();
        s_valid = 1'b0;
        rst = 1'b0;

        // Seventeen beats to port 2 wrap a four-bit counter to 1.
        m_ready = 4'hF;
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 2'd2, 8'(k), 1'b1);
            step();
        end
        s_valid = 1'b0;
        step();
        chk("t6 cnt2", 64'(m_cnt[2*CW +: CW]), CNT_EN ? 64'h1 : 64'h0);
        chk("t6 other cnts", 64'(m_cnt & 16'hF0FF), 64'h0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            m_ready = 4'($urandom);
            drive($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom), $urandom_range(0, 2) == 0);
            step();
        end
        s_valid = 1'b0;
        m_ready = 4'hF;
        step(); step();
        run_cmp = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
        $finish;
    end
endmodule
